// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int          DEFAULT_XLEN     = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          PC_STEP          = 4;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch stage.
interface fetch_if #(
    parameter int XLEN = fetch_pkg::DEFAULT_XLEN
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_instr;

    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        output imem_req, imem_addr, id_valid, id_pc, id_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        input  imem_req, imem_addr, id_valid, id_pc, id_instr
    );
endinterface

// File: rtl/fetch_out_reg.sv
// Single-entry valid/ready register holding the {pc, instr} handed to decode.
module fetch_out_reg #(
    parameter int XLEN = fetch_pkg::DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic            id_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instr,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (load) begin
            id_valid <= 1'b1;
        end else if (id_ready) begin
            id_valid <= 1'b0;
        end
    end

    // NOTE: payload is reset too, so decode sees zeros rather than X before the first fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc    <= '0;
            id_instr <= '0;
        end else if (load && !flush) begin
            id_pc    <= pc;
            id_instr <= instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch PC register, single-outstanding imem request FSM and redirect handling.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] redirect_target;
    logic            buf_free;
    logic            imem_req;
    logic            issue;
    logic            load;

    assign buf_free        = !bus.id_valid || bus.id_ready;
    assign redirect_target = bus.redirect_pc & ~XLEN'(2'b11);
    assign issue           = imem_req && bus.imem_gnt;
    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = fetch_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            REQ: begin
                if (issue) state_next = WAIT;
            end
            WAIT: begin
                if (bus.imem_rvalid)         state_next = REQ;
                else if (bus.redirect_valid) state_next = DISCARD;
            end
            DISCARD: begin
                // A redirect here only moves the PC; the pending response still has to drain.
                if (bus.imem_rvalid) state_next = REQ;
            end
            default: state_next = REQ;
        endcase
    end

    // Request is gated by rst so it drops the instant reset asserts.
    always_comb begin
        imem_req = rst && (state == REQ) && buf_free && !bus.redirect_valid;
        load     = (state == WAIT) && bus.imem_rvalid && !bus.redirect_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else if (bus.redirect_valid) begin
            fetch_pc <= redirect_target;
        end else if (issue) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        end
    end

    fetch_out_reg #(.XLEN(XLEN)) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .flush    (bus.redirect_valid),
        .id_ready (bus.id_ready),
        .pc       (req_pc),
        .instr    (bus.imem_rdata),
        .id_valid (bus.id_valid),
        .id_pc    (bus.id_pc),
        .id_instr (bus.id_instr)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset corner case, random run vs queue model.
module tb_fetch_stage;

    localparam logic [31:0] K        = 32'hA5A5_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          N_VEC    = 30;
    localparam int          N_RAND   = 3000;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_idv;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        bit          live;
    } flight_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fetch_if #(.XLEN(32)) bus ();

    fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t        vecs [N_VEC];
    flight_t     inflight [$];
    logic [31:0] out_q [$];
    logic [31:0] m_pc;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic redir, input logic [31:0] rpc, input logic gnt,
                         input logic rv, input logic [31:0] rdata, input logic ready);
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_gnt       = gnt;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = rdata;
        bus.id_ready       = ready;
    endtask

    function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic gnt,
                                input logic rv, input logic [31:0] rdata, input logic ready,
                                input logic req, input logic [31:0] addr, input logic idv,
                                input logic [31:0] pc, input logic [31:0] instr);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.ready = ready;
        v.exp_req = req; v.exp_addr = addr; v.exp_idv = idv; v.exp_pc = pc; v.exp_instr = instr;
        return v;
    endfunction

    initial begin
        logic exp_req;
        logic redir, gnt, rv, ready;
        logic [31:0] rpc;
        flight_t f;

        // Sequential fetch, stall, redirect in WAIT, redirect with rvalid, flush on stall, wrap.
        vecs[0]  = mk(0, 0, 1, 0, 0,            1, 1, 32'h0,        0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 0, 1, 1, K,            1, 0, 32'h4,        0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 0, 1, 0, 0,            1, 1, 32'h4,        1, 32'h0,        K);
        vecs[3]  = mk(0, 0, 1, 1, K ^ 32'h4,    1, 0, 32'h8,        0, 32'h0,        K);
        vecs[4]  = mk(0, 0, 1, 0, 0,            1, 1, 32'h8,        1, 32'h4,        K ^ 32'h4);
        vecs[5]  = mk(0, 0, 1, 1, K ^ 32'h8,    1, 0, 32'hC,        0, 32'h4,        K ^ 32'h4);
        for (int i = 6; i <= 10; i++)
            vecs[i] = mk(0, 0, 1, 0, 0,         0, 0, 32'hC,        1, 32'h8,        K ^ 32'h8);
        vecs[11] = mk(0, 0, 1, 0, 0,            1, 1, 32'hC,        1, 32'h8,        K ^ 32'h8);
        vecs[12] = mk(0, 0, 1, 1, K ^ 32'hC,    1, 0, 32'h10,       0, 32'h8,        K ^ 32'h8);
        vecs[13] = mk(0, 0, 1, 0, 0,            1, 1, 32'h10,       1, 32'hC,        K ^ 32'hC);
        vecs[14] = mk(1, 32'h103, 0, 0, 0,      1, 0, 32'h14,       0, 32'hC,        K ^ 32'hC);
        vecs[15] = mk(0, 0, 1, 0, 0,            1, 0, 32'h100,      0, 32'hC,        K ^ 32'hC);
        vecs[16] = mk(0, 0, 1, 1, K ^ 32'h10,   1, 0, 32'h100,      0, 32'hC,        K ^ 32'hC);
        vecs[17] = mk(0, 0, 1, 0, 0,            1, 1, 32'h100,      0, 32'hC,        K ^ 32'hC);
        vecs[18] = mk(0, 0, 1, 1, K ^ 32'h100,  1, 0, 32'h104,      0, 32'hC,        K ^ 32'hC);
        vecs[19] = mk(0, 0, 0, 0, 0,            0, 0, 32'h104,      1, 32'h100,      K ^ 32'h100);
        vecs[20] = mk(1, 32'h200, 1, 0, 0,      0, 0, 32'h104,      1, 32'h100,      K ^ 32'h100);
        vecs[21] = mk(0, 0, 1, 0, 0,            0, 1, 32'h200,      0, 32'h100,      K ^ 32'h100);
        vecs[22] = mk(1, 32'h200, 0, 1, K ^ 32'h200, 1, 0, 32'h204, 0, 32'h100,      K ^ 32'h100);
        vecs[23] = mk(0, 0, 1, 0, 0,            1, 1, 32'h200,      0, 32'h100,      K ^ 32'h100);
        vecs[24] = mk(1, 32'hFFFF_FFFE, 0, 0, 0, 1, 0, 32'h204,     0, 32'h100,      K ^ 32'h100);
        vecs[25] = mk(0, 0, 0, 1, K ^ 32'h204,  1, 0, 32'hFFFF_FFFC, 0, 32'h100,     K ^ 32'h100);
        vecs[26] = mk(0, 0, 1, 0, 0,            1, 1, 32'hFFFF_FFFC, 0, 32'h100,     K ^ 32'h100);
        vecs[27] = mk(0, 0, 0, 1, K ^ 32'hFFFF_FFFC, 1, 0, 32'h0,   0, 32'h100,      K ^ 32'h100);
        vecs[28] = mk(0, 0, 0, 0, 0,            1, 1, 32'h0,        1, 32'hFFFF_FFFC, K ^ 32'hFFFF_FFFC);
        vecs[29] = mk(0, 0, 0, 0, 0,            1, 1, 32'h0,        0, 32'hFFFF_FFFC, K ^ 32'hFFFF_FFFC);

        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        check("reset_req",   32'(bus.imem_req), 32'h0);
        check("reset_addr",  bus.imem_addr,     RESET_PC);
        check("reset_idv",   32'(bus.id_valid), 32'h0);
        check("reset_pc",    bus.id_pc,         32'h0);
        check("reset_instr", bus.id_instr,      32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            @(negedge clk);
            drive(vecs[i].redir, vecs[i].rpc, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].ready);
            #1;
            check($sformatf("vec%0d_req", i),   32'(bus.imem_req), 32'(vecs[i].exp_req));
            check($sformatf("vec%0d_addr", i),  bus.imem_addr,     vecs[i].exp_addr);
            check($sformatf("vec%0d_idv", i),   32'(bus.id_valid), 32'(vecs[i].exp_idv));
            check($sformatf("vec%0d_pc", i),    bus.id_pc,         vecs[i].exp_pc);
            check($sformatf("vec%0d_instr", i), bus.id_instr,      vecs[i].exp_instr);
        end

        // Reset asserted between edges while a request is in flight.
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 1);
        #1 check("mid_issue_req", 32'(bus.imem_req), 32'h1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1);
        #1 check("mid_wait_addr", bus.imem_addr, 32'h4);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_req",  32'(bus.imem_req), 32'h0);
        check("mid_rst_idv",  32'(bus.id_valid), 32'h0);
        check("mid_rst_addr", bus.imem_addr,     RESET_PC);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        #1 check("stale_req", 32'(bus.imem_req), 32'h1);
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 1);
        #1;
        check("stale_idv",  32'(bus.id_valid), 32'h0);
        check("stale_addr", bus.imem_addr,     RESET_PC);
        @(negedge clk);
        drive(0, 0, 0, 1, RESET_PC ^ K, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1);
        #1;
        check("post_rst_idv",   32'(bus.id_valid), 32'h1);
        check("post_rst_pc",    bus.id_pc,         RESET_PC);
        check("post_rst_instr", bus.id_instr,      RESET_PC ^ K);

        // Random run against a queue-level model of fetched/delivered PCs.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #2 rst = 1'b1;
        m_pc     = RESET_PC;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        mem_addr = '0;
        inflight.delete();
        out_q.delete();

        for (int c = 0; c < N_RAND; c++) begin
            @(negedge clk);
            redir = ($urandom_range(0, 9) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            gnt   = ($urandom_range(0, 2) != 0);
            ready = ($urandom_range(0, 3) != 0);
            rv    = mem_busy && (mem_cnt == 0);
            drive(redir, rpc, gnt, rv, mem_addr ^ K, ready);
            #1;

            exp_req = (inflight.size() == 0) && (out_q.size() == 0 || ready) && !redir;
            check("rnd_req", 32'(bus.imem_req), 32'(exp_req));
            if (exp_req) check("rnd_addr", bus.imem_addr, m_pc);
            check("rnd_idv", 32'(bus.id_valid), 32'(out_q.size() != 0));
            if (out_q.size() != 0) begin
                check("rnd_pc",    bus.id_pc,    out_q[0]);
                check("rnd_instr", bus.id_instr, out_q[0] ^ K);
            end

            if (rv) mem_busy = 1'b0;
            else if (mem_busy) mem_cnt--;
            if (bus.imem_req && gnt) begin
                mem_busy = 1'b1;
                mem_addr = bus.imem_addr;
                mem_cnt  = $urandom_range(0, 2);
            end

            if (redir) begin
                m_pc = rpc & ~32'h3;
                out_q.delete();
                if (inflight.size() != 0) begin
                    if (rv) inflight.delete();
                    else    inflight[0].live = 1'b0;
                end
            end else begin
                if (out_q.size() != 0 && ready) void'(out_q.pop_front());
                if (rv && inflight.size() != 0) begin
                    f = inflight.pop_front();
                    if (f.live) out_q.push_back(f.pc);
                end
                if (exp_req && gnt) begin
                    inflight.push_back('{pc: m_pc, live: 1'b1});
                    m_pc = m_pc + 32'd4;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that owns the fetch PC register and computes next PC (pc+4, or a redirect target).
- Issues one instruction-memory request at a time and returns {pc, instr} to decode through a single-entry valid/ready output register.
- Sits between the branch/jump resolution logic (source of redirects) and the decode stage.

Parameters:
XLEN, 32, PC and instruction width
RESET_PC, 32'h0000_0000, fetch PC loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
redirect_valid  in  1  branch/jump taken; load redirect_pc, flush in-flight fetch
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored, forced to 0
imem_req  out  1  memory request valid
imem_addr  out  XLEN  request address (= fetch PC)
imem_gnt  in  1  memory accepts request in the same cycle as imem_req
imem_rvalid  in  1  response valid; at least 1 cycle after grant
imem_rdata  in  XLEN  instruction word
id_valid  out  1  decode output valid
id_ready  in  1  decode accepts the output
id_pc  out  XLEN  PC of the delivered instruction
id_instr  out  XLEN  delivered instruction

Behaviour:
- Reset (rst=0, immediate, no clock needed):
  - fetch_pc=RESET_PC, state=REQ.
  - Outputs: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_pc=0, id_instr=0.
- States: REQ, WAIT, DISCARD. At most one outstanding request.
- buf_free = !id_valid || id_ready.
- REQ:
  - imem_req = buf_free && !redirect_valid; imem_addr = fetch_pc.
  - On imem_req && imem_gnt: req_pc <= fetch_pc; fetch_pc <= fetch_pc+4 (mod 2^XLEN, 0xFFFF_FFFC wraps to 0); go to WAIT.
  - imem_rvalid is ignored in REQ.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: id_valid<=1, id_pc<=req_pc, id_instr<=imem_rdata; go to REQ.
  - The output buffer is guaranteed empty at this point: issue required buf_free, and only one request is outstanding.
- DISCARD:
  - imem_req=0.
  - On imem_rvalid: drop the data; go to REQ.
- Output handshake:
  - id_valid && id_ready consumes the entry; id_valid<=0 unless refilled the same cycle.
  - While id_valid && !id_ready: id_pc and id_instr stay stable.
- Redirect (highest priority, any state):
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - id_valid<=0 (buffer flushed regardless of id_ready).
  - REQ: imem_req is forced 0 that cycle; stay in REQ.
  - WAIT without rvalid: go to DISCARD.
  - WAIT with rvalid the same cycle: drop the data; go to REQ.
  - DISCARD: update fetch_pc only; stay in DISCARD.
- Latency:
  - Redirect to first request at the target: 1 cycle.
  - With gnt in the same cycle and rvalid 1 cycle later, throughput is 1 instruction per 2 cycles.
- Reset mid-WAIT: the in-flight response is lost; a stale rvalid after release arrives in REQ and is ignored.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {REQ, WAIT, DISCARD}.
  - PC_STEP = 4.
  - Default XLEN and RESET_PC.
- Sub-module fetch_out_reg: single-entry valid/ready register, with inputs load, flush, pc, instr and outputs id_*.
- fetch_stage holds the FSM and PC arithmetic.

Test Plan:
1. Release reset; memory grants every request and returns rdata = addr ^ 32'hA5A5_0000 one cycle after grant; id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8, 0xC; id_pc 0x0, 0x4, 0x8, 0xC with matching id_instr; at most one grant per 2 cycles.
2. Hold id_ready=0 for 5 cycles while id_valid=1 with id_pc=0x8 -> id_pc/id_instr stay stable and imem_req=0; raise id_ready -> next imem_addr=0xC.
3. Grant request at 0x10, then redirect_valid=1 with redirect_pc=0x103 in WAIT, rvalid arrives 2 cycles later -> 0x10 never appears on id_*, state passes through DISCARD, next imem_addr=0x100, first id_pc=0x100.
4. Redirect to 0x200 in the same cycle as rvalid in WAIT -> data dropped, no DISCARD, imem_req=1 with addr 0x200 the next cycle. Redirect while id_valid=1 and id_ready=0 -> id_valid=0 the next cycle.
5. Redirect to 0xFFFF_FFFC and complete the fetch -> next imem_addr=0x0000_0000 (wrap).
6. Drive rst=0 mid-WAIT between clock edges -> immediately imem_req=0, id_valid=0, imem_addr=RESET_PC; rvalid after release is ignored; first id_pc=RESET_PC.
